// File: rtl/opad_pkg.sv
// Shared types and helpers for the serialising output pad.
package opad_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } opad_state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bit counter width; a one-bit floor keeps degenerate widths elaboratable.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/opad_serdes_if.sv
// Parallel-in handshake and serial pad bundle for opad_serdes.
interface opad_serdes_if #(
  parameter int CHANNELS = 1,
  parameter int WIDTH    = 4
);
  logic [CHANNELS*WIDTH-1:0] din;
  logic                      din_valid;
  logic                      din_ready;
  logic                      flush;
  logic [CHANNELS-1:0]       outpad;
  logic [CHANNELS-1:0]       oe;
  logic                      busy;
  logic                      underrun;

  modport master (
    output din, din_valid, flush,
    input  din_ready, outpad, oe, busy, underrun
  );

  modport slave (
    input  din, din_valid, flush,
    output din_ready, outpad, oe, busy, underrun
  );
endinterface

// File: rtl/opad_shift_lane.sv
// One serialiser lane: WIDTH-bit shifter feeding a registered pad bit.
module opad_shift_lane #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_idle,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_pad
);

  logic [WIDTH-1:0] r_shift;
  logic             r_pad;

  function automatic logic first_bit(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? d[WIDTH-1] : d[0];
  endfunction

  // The shifter always holds the not-yet-driven bits aligned at the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? {d[WIDTH-2:0], 1'b0} : {1'b0, d[WIDTH-1:1]};
  endfunction

  // Shifter and pad flop: idle has priority, then load, then shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= {WIDTH{1'b0}};
      r_pad   <= IDLE_LEVEL;
    end else if (i_idle) begin
      r_pad   <= IDLE_LEVEL;
    end else if (i_load) begin
      r_pad   <= first_bit(i_data);
      r_shift <= advance(i_data);
    end else if (i_shift) begin
      r_pad   <= first_bit(r_shift);
      r_shift <= advance(r_shift);
    end else begin
      r_pad   <= r_pad;
    end
  end

  assign o_pad = r_pad;

endmodule

// File: rtl/opad_serdes.sv
// Multi-lane output pad with parallel-to-serial conversion and a one-word holding buffer.
module opad_serdes
  import opad_pkg::*;
#(
  parameter int CHANNELS   = 1,
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter bit OE_IDLE    = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  opad_serdes_if.slave  bus
);

  localparam int                  CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]       CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CHANNELS-1:0] OE_IDLE_V = {CHANNELS{OE_IDLE}};
  localparam logic [CHANNELS-1:0] OE_ON_V   = {CHANNELS{1'b1}};

  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
    $error("opad_serdes: WIDTH must lie in 2..32");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("opad_serdes: CHANNELS must be at least 1");
  end

  opad_state_e               r_state;
  logic [CW-1:0]             r_cnt;
  logic [CHANNELS*WIDTH-1:0] r_hold;
  logic                      r_hold_full;
  logic                      r_din_ready;
  logic [CHANNELS-1:0]       r_oe;
  logic                      r_underrun;

  opad_state_e               w_state_nxt;
  logic [CW-1:0]             w_cnt_nxt;
  logic                      w_hold_full_nxt;
  logic [CHANNELS-1:0]       w_oe_nxt;
  logic                      w_underrun_nxt;
  logic                      w_load;
  logic                      w_shift;
  logic                      w_idle;
  logic                      w_accept;
  logic [CHANNELS-1:0]       w_pad;

  assign w_accept = bus.din_valid && r_din_ready;

  // Next-state, lane controls and holding-buffer occupancy; flush overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hold_full_nxt = r_hold_full;
    w_oe_nxt        = r_oe;
    w_underrun_nxt  = 1'b0;
    w_load          = 1'b0;
    w_shift         = 1'b0;
    w_idle          = 1'b0;
    if (bus.flush) begin
      w_state_nxt     = ST_IDLE;
      w_idle          = 1'b1;
      w_oe_nxt        = OE_IDLE_V;
      w_hold_full_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_cnt_nxt   = {CW{1'b0}};
            w_oe_nxt    = OE_ON_V;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_idle      = 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            if (r_hold_full) begin
              w_load         = 1'b1;
              w_cnt_nxt      = {CW{1'b0}};
            end else begin
              w_state_nxt    = ST_IDLE;
              w_idle         = 1'b1;
              w_oe_nxt       = OE_IDLE_V;
              w_underrun_nxt = 1'b1;
            end
          end else begin
            w_shift   = 1'b1;
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idle      = 1'b1;
          w_oe_nxt    = OE_IDLE_V;
          w_cnt_nxt   = {CW{1'b0}};
        end
      endcase
      // Accept and drain are mutually exclusive because ready is low while full.
      if (w_load) begin
        w_hold_full_nxt = 1'b0;
      end else if (w_accept) begin
        w_hold_full_nxt = 1'b1;
      end else begin
        w_hold_full_nxt = r_hold_full;
      end
    end
  end

  // Control state registers; ready is a registered copy of !hold_full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_hold_full <= 1'b0;
      r_din_ready <= 1'b1;
      r_oe        <= OE_IDLE_V;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_din_ready <= !w_hold_full_nxt;
      r_oe        <= w_oe_nxt;
      r_underrun  <= w_underrun_nxt;
    end
  end

  // Holding buffer captures a word only when it is accepted and not flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= {(CHANNELS*WIDTH){1'b0}};
    end else if (w_accept && !bus.flush) begin
      r_hold <= bus.din;
    end else begin
      r_hold <= r_hold;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    opad_shift_lane #(
      .WIDTH      (WIDTH),
      .MSB_FIRST  (MSB_FIRST),
      .IDLE_LEVEL (IDLE_LEVEL)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_idle  (w_idle),
      .i_data  (r_hold[c*WIDTH +: WIDTH]),
      .o_pad   (w_pad[c])
    );
  end

  assign bus.din_ready = r_din_ready;
  assign bus.outpad    = w_pad;
  assign bus.oe        = r_oe;
  assign bus.busy      = (r_state == ST_SHIFT);
  assign bus.underrun  = r_underrun;

endmodule
